// File: rtl/ber_sync_sequencer.sv
// ber_sync_sequencer: sweeps BER-counter latency offsets, then supervises lock in counting mode
//   clk, i_reset (sync, active-low), i_ctrl (symbol strobe), i_en_rx, i_start, i_auto_resync
//   i_accum_err / i_accum_tot : BER counter accumulators (64 bit)
//   o_ber_clear (1-clk counter reset), o_synchro_en, o_prbs_cmp_curr_addr_done, o_ber_counter_en
//   o_state (0 IDLE, 1 CLEAR, 2 SWEEP, 3 LOCKED), o_offset_idx, o_lock_lost (1-clk), o_sync_cnt
module ber_sync_sequencer #(
    parameter int PRBS_MAX_CYCLES = 511,
    parameter int WIN_LEN = 511,
    parameter int CHK_LEN = 4096,
    parameter int THR_SHIFT = 6,
    localparam int OFF_W = (PRBS_MAX_CYCLES > 1) ? $clog2(PRBS_MAX_CYCLES) : 1
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_ctrl,
    input  logic             i_en_rx,
    input  logic             i_start,
    input  logic             i_auto_resync,
    input  logic [63:0]      i_accum_err,
    input  logic [63:0]      i_accum_tot,
    output logic             o_ber_clear,
    output logic             o_synchro_en,
    output logic             o_prbs_cmp_curr_addr_done,
    output logic             o_ber_counter_en,
    output logic [1:0]       o_state,
    output logic [OFF_W-1:0] o_offset_idx,
    output logic             o_lock_lost,
    output logic [15:0]      o_sync_cnt
);
    localparam int SC_W = $clog2(WIN_LEN + 1);
    localparam int CC_W = (CHK_LEN > 1) ? $clog2(CHK_LEN) : 1;
    localparam logic [63:0] THR = 64'(CHK_LEN >> THR_SHIFT);

    typedef enum logic [1:0] {IDLE, CLEAR, SWEEP, LOCKED} state_t;

    state_t state, state_n;
    logic [SC_W-1:0] sc, sc_n;
    logic [CC_W-1:0] cc, cc_n;
    logic [63:0] err0, err0_n;
    logic [OFF_W-1:0] idx_n;
    logic [15:0] sync_cnt_n;
    logic ber_clear_n, synchro_n, done_n, ber_en_n, lock_lost_n;
    logic last_off, chk_pt, lost;

    assign o_state = state;
    assign last_off = o_prbs_cmp_curr_addr_done && o_offset_idx == OFF_W'(PRBS_MAX_CYCLES - 1);
    assign chk_pt = i_ctrl && cc == CC_W'(CHK_LEN - 1);
    // Modulo subtraction keeps the window delta correct across accumulator wrap.
    assign lost = chk_pt && i_accum_tot >= 64'(CHK_LEN) && (i_accum_err - err0) > THR;

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            state <= IDLE;
            sc <= '0;
            cc <= '0;
            err0 <= '0;
            o_ber_clear <= 1'b0;
            o_synchro_en <= 1'b0;
            o_prbs_cmp_curr_addr_done <= 1'b0;
            o_ber_counter_en <= 1'b0;
            o_offset_idx <= '0;
            o_lock_lost <= 1'b0;
            o_sync_cnt <= '0;
        end else begin
            state <= state_n;
            sc <= sc_n;
            cc <= cc_n;
            err0 <= err0_n;
            o_ber_clear <= ber_clear_n;
            o_synchro_en <= synchro_n;
            o_prbs_cmp_curr_addr_done <= done_n;
            o_ber_counter_en <= ber_en_n;
            o_offset_idx <= idx_n;
            o_lock_lost <= lock_lost_n;
            o_sync_cnt <= sync_cnt_n;
        end
    end

    // Disable beats restart, restart beats any done/check event on the same edge.
    always_comb begin
        state_n = !i_en_rx ? IDLE :
                  i_start ? CLEAR :
                  state == CLEAR ? SWEEP :
                  (state == SWEEP && i_ctrl && last_off) ? LOCKED :
                  (state == LOCKED && lost && i_auto_resync) ? CLEAR : state;
    end

    always_comb begin
        ber_clear_n = state_n == CLEAR;
        lock_lost_n = i_en_rx && !i_start && state == LOCKED && lost;
        synchro_n = o_synchro_en;
        done_n = o_prbs_cmp_curr_addr_done;
        ber_en_n = o_ber_counter_en;
        idx_n = o_offset_idx;
        sc_n = sc;
        cc_n = cc;
        err0_n = err0;
        sync_cnt_n = o_sync_cnt;
        if (state_n == IDLE || state_n == CLEAR) begin
            synchro_n = 1'b0;
            done_n = 1'b0;
            ber_en_n = 1'b0;
            idx_n = '0;
            sc_n = '0;
            cc_n = '0;
        end else if (state == CLEAR) begin
            synchro_n = 1'b1;
        end else if (state == SWEEP && state_n == LOCKED) begin
            synchro_n = 1'b0;
            done_n = 1'b0;
            ber_en_n = 1'b1;
            sc_n = '0;
            cc_n = '0;
            err0_n = i_accum_err;
            sync_cnt_n = (&o_sync_cnt) ? o_sync_cnt : o_sync_cnt + 16'd1;
        end else if (i_ctrl && state == SWEEP) begin
            // done is raised after WIN_LEN strobes and held across exactly one more.
            done_n = !o_prbs_cmp_curr_addr_done && sc == SC_W'(WIN_LEN - 1);
            sc_n = o_prbs_cmp_curr_addr_done ? '0 : sc + 1'b1;
            idx_n = o_prbs_cmp_curr_addr_done ? o_offset_idx + 1'b1 : o_offset_idx;
        end else if (i_ctrl) begin
            cc_n = chk_pt ? '0 : cc + 1'b1;
            err0_n = chk_pt ? i_accum_err : err0;
        end
    end
endmodule

// File: tb/tb_ber_sync_sequencer.sv
// tb_ber_sync_sequencer: scoreboard bench for ber_sync_sequencer (7 offsets, 7-strobe windows, 64-strobe checks)
module tb_ber_sync_sequencer;
    logic clk, i_reset, i_ctrl, i_en_rx, i_start, i_auto_resync;
    logic [63:0] i_accum_err, i_accum_tot;
    logic o_ber_clear, o_synchro_en, o_done, o_ber_counter_en, o_lock_lost;
    logic [1:0] o_state;
    logic [2:0] o_offset_idx;
    logic [15:0] o_sync_cnt;

    typedef struct {int idx; int strb;} exp_t;
    exp_t exp_q[$];
    int errors = 0, checks = 0, ph = 0, sweep_strb = 0, dhi = 0, lost_cnt = 0, inv_bad = 0;
    bit ok;

    ber_sync_sequencer #(.PRBS_MAX_CYCLES(7), .WIN_LEN(7), .CHK_LEN(64), .THR_SHIFT(3)) dut (
        .clk(clk), .i_reset(i_reset), .i_ctrl(i_ctrl), .i_en_rx(i_en_rx), .i_start(i_start),
        .i_auto_resync(i_auto_resync), .i_accum_err(i_accum_err), .i_accum_tot(i_accum_tot),
        .o_ber_clear(o_ber_clear), .o_synchro_en(o_synchro_en), .o_prbs_cmp_curr_addr_done(o_done),
        .o_ber_counter_en(o_ber_counter_en), .o_state(o_state), .o_offset_idx(o_offset_idx),
        .o_lock_lost(o_lock_lost), .o_sync_cnt(o_sync_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_sweep();
        exp_q.delete();
        for (int k = 0; k < 7; k++) exp_q.push_back('{k, 7 + 8 * k});
    endtask

    // One clock: advance past the edge, score what the DUT produced, then drive the strobe.
    task automatic tick();
        logic [1:0] st_b;
        logic c_b, d_b;
        exp_t e;
        st_b = o_state;
        c_b = i_ctrl;
        d_b = o_done;
        @(posedge clk);
        #1;
        if (st_b == 2'd2 && c_b) sweep_strb++;
        if (o_state == 2'd1) sweep_strb = 0;
        if (o_lock_lost) lost_cnt++;
        if ((o_synchro_en && o_ber_counter_en) || (o_done && !o_synchro_en)) inv_bad++;
        if (o_done && !d_b) begin
            if (exp_q.size() == 0) check("done_extra", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("done_idx", o_offset_idx, e.idx);
                check("done_strobe", sweep_strb, e.strb);
            end
        end
        if (o_done) dhi++;
        if (!o_done && d_b) begin
            if (o_state >= 2'd2) check("done_width", dhi, 4);
            dhi = 0;
        end
        ph = (ph + 1) % 4;
        i_ctrl = ph == 0;
    endtask

    task automatic wait_for(input int sel, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = sel == 0 ? o_ber_counter_en : o_lock_lost;
        end
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    initial begin
        i_reset = 1'b0; i_ctrl = 1'b0; i_en_rx = 1'b1; i_start = 1'b0; i_auto_resync = 1'b1;
        i_accum_err = 64'd0; i_accum_tot = 64'd1000;
        repeat (3) tick();
        inv_bad = 0; dhi = 0; lost_cnt = 0;
        check("rst_state", o_state, 0);
        check("rst_clear", o_ber_clear, 0);
        check("rst_synchro", o_synchro_en, 0);
        check("rst_ber_en", o_ber_counter_en, 0);
        check("rst_idx", o_offset_idx, 0);
        check("rst_sync_cnt", o_sync_cnt, 0);
        i_reset = 1'b1;
        repeat (4) tick();
        check("idle_no_autostart", o_state, 0);

        expect_sweep();
        pulse_start();
        check("start_state", o_state, 1);
        check("start_clear", o_ber_clear, 1);
        tick();
        check("sweep_state", o_state, 2);
        check("sweep_clear_1clk", o_ber_clear, 0);
        check("sweep_synchro", o_synchro_en, 1);
        check("sweep_idx0", o_offset_idx, 0);
        wait_for(0, 400, ok);
        check("lock_seen", ok, 1);
        check("lock_state", o_state, 3);
        check("lock_strobes", sweep_strb, 56);
        check("lock_idx", o_offset_idx, 6);
        check("lock_synchro", o_synchro_en, 0);
        check("lock_sync_cnt", o_sync_cnt, 1);
        check("lock_all_done", exp_q.size(), 0);

        i_accum_err += 64'd8;
        repeat (270) tick();
        check("err8_no_lost", lost_cnt, 0);
        check("err8_state", o_state, 3);
        i_accum_tot = 64'd10;
        i_accum_err += 64'd20;
        repeat (270) tick();
        check("lowtot_no_lost", lost_cnt, 0);
        i_accum_tot = 64'd1000;
        i_accum_err += 64'd9;
        wait_for(1, 300, ok);
        check("err9_lost", ok, 1);
        check("err9_state", o_state, 1);
        check("err9_clear", o_ber_clear, 1);
        check("err9_ber_en", o_ber_counter_en, 0);
        expect_sweep();
        wait_for(0, 400, ok);
        check("resync_lock", ok, 1);
        check("resync_sync_cnt", o_sync_cnt, 2);

        i_auto_resync = 1'b0;
        i_accum_err += 64'd20;
        wait_for(1, 300, ok);
        check("noauto_lost", ok, 1);
        check("noauto_state", o_state, 3);
        check("noauto_ber_en", o_ber_counter_en, 1);
        tick();
        check("lost_1clk", o_lock_lost, 0);
        check("noauto_state2", o_state, 3);

        expect_sweep();
        pulse_start();
        check("restart_state", o_state, 1);
        check("restart_ber_en", o_ber_counter_en, 0);
        check("restart_clear", o_ber_clear, 1);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            tick();
            ok = o_done && o_offset_idx == 3'd4 && i_ctrl;
        end
        check("reach_done4", ok, 1);
        pulse_start();
        check("startdone_state", o_state, 1);
        check("startdone_idx", o_offset_idx, 0);
        check("startdone_done", o_done, 0);
        check("startdone_synchro", o_synchro_en, 0);
        expect_sweep();
        tick();
        check("startdone_sweep", o_state, 2);

        repeat (40) tick();
        i_en_rx = 1'b0;
        tick();
        check("enrx_state", o_state, 0);
        check("enrx_synchro", o_synchro_en, 0);
        check("enrx_ber_en", o_ber_counter_en, 0);
        check("enrx_done", o_done, 0);
        check("enrx_idx", o_offset_idx, 0);
        check("enrx_sync_kept", o_sync_cnt, 2);
        i_en_rx = 1'b1;
        repeat (8) tick();
        check("enrx_no_autostart", o_state, 0);

        expect_sweep();
        pulse_start();
        repeat (40) tick();
        check("pre_reset_sweep", o_state, 2);
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
        check("midrst_state", o_state, 0);
        check("midrst_synchro", o_synchro_en, 0);
        check("midrst_sync_cnt", o_sync_cnt, 0);

        check("invariants", inv_bad, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ber_sync_sequencer.md
Name: ber_sync_sequencer

Overview:
- Sequences the receiver BER counter.
- On start, it resets the counter and sweeps every candidate latency offset. For each offset it holds a fixed comparison window and then pulses "current address done". After the sweep it switches the counter to BER counting mode.
- In counting mode it watches the accumulated error/total values. If a window exceeds the error threshold, it declares loss of lock and, optionally, re-synchronises.
- Sits between the uBlaze register bank and the BER counter in the RX path.

Parameters:
- PRBS_MAX_CYCLES, 511: number of candidate offsets swept; must match the BER counter.
- WIN_LEN, 511: symbol strobes compared per offset before the done strobe.
- CHK_LEN, 4096: symbol strobes per lock-check window in counting mode.
- THR_SHIFT, 6: lost-lock when window errors > CHK_LEN >> THR_SHIFT.

Ports:
- clk  in  1  system clock
- i_reset  in  1  synchronous, active-low reset
- i_ctrl  in  1  one-cycle symbol strobe (1 per BR period), shared with BER counter
- i_en_rx  in  1  RX enable; 0 forces IDLE
- i_start  in  1  uBlaze start/restart pulse
- i_auto_resync  in  1  1 = re-sync automatically on loss of lock
- i_accum_err  in  64  BER counter error accumulator
- i_accum_tot  in  64  BER counter total accumulator
- o_ber_clear  out  1  one-clk pulse; gate into BER counter reset
- o_synchro_en  out  1  to counter i_synchro_en
- o_prbs_cmp_curr_addr_done  out  1  to counter i_prbs_cmp_curr_addr_done
- o_ber_counter_en  out  1  to counter i_ber_counter_en
- o_state  out  2  0=IDLE 1=CLEAR 2=SWEEP 3=LOCKED
- o_offset_idx  out  log2(PRBS_MAX_CYCLES)  offset currently being swept
- o_lock_lost  out  1  one-clk pulse on loss-of-lock detection
- o_sync_cnt  out  16  completed sweeps, saturating at 0xFFFF

Behaviour:
- All outputs are registered. Reset (i_reset==0) or i_en_rx==0 forces:
  - state IDLE;
  - all control outputs 0, o_offset_idx 0, window counters 0;
  - o_sync_cnt 0 (reset only; i_en_rx==0 keeps it).
- Strobe alignment:
  - Control-output changes in SWEEP/LOCKED occur only on clk edges where i_ctrl==1.
  - The counter therefore sees a value that is stable across exactly one following strobe.
- IDLE: on i_start==1, go to CLEAR with o_ber_clear=1 for exactly one clk.
- CLEAR:
  - Next clk: go to SWEEP with o_synchro_en=1, o_offset_idx=0, strobe count sc=0.
  - Does not wait for i_ctrl.
- SWEEP, per offset:
  - WIN_LEN strobes with done=0, then exactly one strobe with done=1.
  - On the strobe where sc==WIN_LEN-1: set done=1.
  - On the next strobe: clear done, sc=0, o_offset_idx++.
  - One offset therefore takes WIN_LEN+1 strobes. Full sweep = PRBS_MAX_CYCLES*(WIN_LEN+1) strobes.
- End of sweep: on the strobe that clears done for offset PRBS_MAX_CYCLES-1:
  - o_synchro_en=0, o_ber_counter_en=1;
  - o_offset_idx holds PRBS_MAX_CYCLES-1;
  - o_sync_cnt++ (saturating);
  - state LOCKED, check counter cc=0, snapshot err0=i_accum_err.
- LOCKED:
  - cc counts strobes.
  - On the strobe where cc==CHK_LEN-1, compute delta = i_accum_err - err0 (64-bit, modulo).
    - If delta > (CHK_LEN>>THR_SHIFT): pulse o_lock_lost for one clk.
      - If i_auto_resync=1: clear o_ber_counter_en, go to CLEAR.
      - Else: stay LOCKED.
    - Snapshot err0 again, cc=0.
  - i_accum_tot is used only to qualify the check: a check is skipped (no lock_lost) if i_accum_tot < CHK_LEN.
- i_start in SWEEP or LOCKED: restart immediately.
  - Enter CLEAR, drop all enables the same clk, o_ber_clear pulse.
  - i_start has priority over a coincident done or check event.
- i_en_rx falling mid-operation: IDLE next clk, no o_lock_lost. i_en_rx rising does not auto-start; i_start is required.
- Invariant: o_synchro_en and o_ber_counter_en are never both 1. done is only 1 while o_synchro_en=1.
- i_ctrl absent: all counters and outputs hold.

Test Plan:
- PRBS_MAX_CYCLES=7, WIN_LEN=7, i_ctrl every 4 clk; pulse i_start -> o_ber_clear 1 clk, then:
  - exactly 7 done pulses, each 1 strobe wide, 8 strobes apart;
  - o_offset_idx 0..6;
  - o_ber_counter_en rises after 56 strobes; o_sync_cnt=1.
- Same config, full loop with BER counter and PRBS source delayed by 3 -> counter latency=3; i_accum_err stays 0 in LOCKED.
- LOCKED, CHK_LEN=64, THR_SHIFT=3, force 9 errors in a window, i_auto_resync=1 -> o_lock_lost pulse, CLEAR, new sweep, o_sync_cnt=2. Same with 8 errors -> no pulse.
- i_auto_resync=0, 20 errors in window -> o_lock_lost pulses, o_ber_counter_en stays 1, state stays 3.
- i_start asserted on the same clk as a done strobe at offset 4 -> CLEAR wins, o_offset_idx=0, no idx increment.
- i_reset=0 and, separately, i_en_rx=0 mid-SWEEP -> next clk all enables 0, state 0. o_sync_cnt cleared only by i_reset.
